// File: rtl/pri_enc_scan_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | pri_enc_scan_if : request-in / index-out handshake bundle            |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface pri_enc_scan_if #(
   parameter int WIDTH = 8
);
   localparam int IDX_W = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x;
   logic             mode;
   logic             out_valid;
   logic             out_ready;
   logic [IDX_W-1:0] y;
   logic             idc;
   logic             out_last;

   modport master (
      output in_valid, x, mode, out_ready,
      input  in_ready, out_valid, y, idc, out_last
   );

   modport slave (
      input  in_valid, x, mode, out_ready,
      output in_ready, out_valid, y, idc, out_last
   );
endinterface
`default_nettype wire

// File: rtl/pri_enc_scan.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | pri_enc_scan : handshaked priority encoder with optional bit drain   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module pri_enc_scan #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   pri_enc_scan_if.slave  bus
);
   localparam int IDX_W = $clog2(WIDTH);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_pend;
   logic             r_mode;
   logic             r_zero;

   logic [IDX_W-1:0] w_idx;
   logic [WIDTH-1:0] w_sel;
   logic [WIDTH-1:0] w_rest;
   logic             w_busy;
   logic             w_last;

   // Later matches overwrite earlier ones, so scan direction sets priority.
   always_comb begin
      w_idx = '0;
      if (MSB_FIRST) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (r_pend[i]) w_idx = IDX_W'(i);
         end
      end else begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (r_pend[i]) w_idx = IDX_W'(i);
         end
      end
   end

   assign w_sel  = WIDTH'(1) << w_idx;
   assign w_rest = r_pend & ~w_sel;
   assign w_busy = (r_state == BUSY);
   assign w_last = r_zero | ~r_mode | (w_rest == '0);

   // rst gates in_ready so it is low for the whole reset window, not just after an edge.
   assign bus.in_ready  = ~rst & en & ~w_busy;
   assign bus.out_valid = w_busy;
   assign bus.y         = (w_busy & ~r_zero) ? w_idx : '0;
   assign bus.idc       = w_busy & ~r_zero;
   assign bus.out_last  = w_busy & w_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_pend  <= '0;
         r_mode  <= 1'b0;
         r_zero  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid && en) begin
                  r_pend  <= bus.x;
                  r_mode  <= bus.mode;
                  r_zero  <= (bus.x == '0);
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               if (bus.out_ready) begin
                  if (w_last) begin
                     r_pend  <= '0;
                     r_state <= IDLE;
                  end else begin
                     r_pend  <= w_rest;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_pri_enc_scan.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pri_enc_scan : three encoder variants against a list-based model  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_pri_enc_scan;
   logic        clk  = 1'b0;
   logic        rst  = 1'b0;
   logic        en   = 1'b0;
   logic        iv   = 1'b0;
   logic        md   = 1'b0;
   logic        ordy = 1'b0;
   logic [15:0] xin  = '0;

   int cmp_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   pri_enc_scan_if #(.WIDTH(8))  if0 ();
   pri_enc_scan_if #(.WIDTH(8))  if1 ();
   pri_enc_scan_if #(.WIDTH(16)) if2 ();

   assign if0.in_valid = iv;  assign if0.x = xin[7:0]; assign if0.mode = md; assign if0.out_ready = ordy;
   assign if1.in_valid = iv;  assign if1.x = xin[7:0]; assign if1.mode = md; assign if1.out_ready = ordy;
   assign if2.in_valid = iv;  assign if2.x = xin;      assign if2.mode = md; assign if2.out_ready = ordy;

   pri_enc_scan #(.WIDTH(8),  .MSB_FIRST(1'b1)) u_msb8  (.clk(clk), .rst(rst), .en(en), .bus(if0.slave));
   pri_enc_scan #(.WIDTH(8),  .MSB_FIRST(1'b0)) u_lsb8  (.clk(clk), .rst(rst), .en(en), .bus(if1.slave));
   pri_enc_scan #(.WIDTH(16), .MSB_FIRST(1'b1)) u_msb16 (.clk(clk), .rst(rst), .en(en), .bus(if2.slave));

   logic a_ov[3], a_ir[3], a_idc[3], a_last[3];
   int   a_y[3];
   assign a_ov[0] = if0.out_valid; assign a_ir[0] = if0.in_ready; assign a_idc[0] = if0.idc;
   assign a_ov[1] = if1.out_valid; assign a_ir[1] = if1.in_ready; assign a_idc[1] = if1.idc;
   assign a_ov[2] = if2.out_valid; assign a_ir[2] = if2.in_ready; assign a_idc[2] = if2.idc;
   assign a_last[0] = if0.out_last; assign a_y[0] = int'(if0.y);
   assign a_last[1] = if1.out_last; assign a_y[1] = int'(if1.y);
   assign a_last[2] = if2.out_last; assign a_y[2] = int'(if2.y);

   // Model: each captured vector becomes an ordered list of beats to emit.
   int wd[3]  = '{8, 8, 16};
   bit msb[3] = '{1'b1, 1'b0, 1'b1};
   bit busy[3];
   bit zero[3];
   int lst[3][16];
   int cnt[3];
   int head[3];

   function automatic void load(int k);
      logic [15:0] v;
      v = (wd[k] == 16) ? xin : {8'h00, xin[7:0]};
      cnt[k]  = 0;
      head[k] = 0;
      busy[k] = 1'b1;
      zero[k] = (v == 16'h0000);
      if (zero[k]) begin
         lst[k][0] = 0;
         cnt[k]    = 1;
      end else begin
         for (int j = 0; j < wd[k]; j++) begin
            int b;
            b = msb[k] ? (wd[k] - 1 - j) : j;
            if (v[b]) begin
               lst[k][cnt[k]] = b;
               cnt[k]++;
            end
         end
         if (!md) cnt[k] = 1;
      end
   endfunction

   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            busy[k] = 1'b0;
            cnt[k]  = 0;
            head[k] = 0;
         end else if (busy[k]) begin
            if (ordy) begin
               head[k]++;
               if (head[k] == cnt[k]) busy[k] = 1'b0;
            end
         end else if (en && iv) begin
            load(k);
         end
      end
   end

   task automatic chk(string nm, int act, int exp);
      cmp_cnt++;
      if (act != exp) begin
         err_cnt++;
         $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
      end
   endtask

   task automatic compare_all();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("dut%0d out_valid", k), int'(a_ov[k]), int'(busy[k]));
         chk($sformatf("dut%0d in_ready", k), int'(a_ir[k]), int'(!rst && en && !busy[k]));
         chk($sformatf("dut%0d y", k), a_y[k], busy[k] ? lst[k][head[k]] : 0);
         chk($sformatf("dut%0d idc", k), int'(a_idc[k]), int'(busy[k] && !zero[k]));
         chk($sformatf("dut%0d out_last", k), int'(a_last[k]), int'(busy[k] && (head[k] == cnt[k] - 1)));
      end
   endtask

   task automatic lit(int k, string nm, int ov, int y, int idc, int last);
      chk($sformatf("%s dut%0d out_valid", nm, k), int'(a_ov[k]), ov);
      chk($sformatf("%s dut%0d y", nm, k), a_y[k], y);
      chk($sformatf("%s dut%0d idc", nm, k), int'(a_idc[k]), idc);
      chk($sformatf("%s dut%0d out_last", nm, k), int'(a_last[k]), last);
   endtask

   task automatic tick();
      @(negedge clk);
      compare_all();
   endtask

   task automatic pulse_reset(string nm);
      rst = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) lit(k, nm, 0, 0, 0, 0);
      compare_all();
      #3;
      rst = 1'b0;
   endtask

   initial begin
      int b0, b2, r;
      en = 1'b1;
      #1 rst = 1'b1;
      #2;
      for (int k = 0; k < 3; k++) begin
         lit(k, "reset", 0, 0, 0, 0);
         chk($sformatf("reset dut%0d in_ready", k), int'(a_ir[k]), 0);
      end
      compare_all();
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("release in_ready", int'(a_ir[0]), 1);

      // Single mode picks one winner
      iv = 1'b1; xin = 16'h0026; md = 1'b0; ordy = 1'b1;
      tick(); lit(0, "single", 1, 5, 1, 1); lit(1, "single", 1, 1, 1, 1);
      iv = 1'b0;
      tick(); chk("single in_ready after", int'(a_ir[0]), 1); lit(0, "single idle", 0, 0, 0, 0);

      // Scan drain 7,2,0 (MSB) and 0,2,7 (LSB)
      iv = 1'b1; xin = 16'h0085; md = 1'b1;
      tick(); lit(0, "scan b0", 1, 7, 1, 0); lit(1, "scan b0", 1, 0, 1, 0);
      iv = 1'b0;
      tick(); lit(0, "scan b1", 1, 2, 1, 0); lit(1, "scan b1", 1, 2, 1, 0);
      tick(); lit(0, "scan b2", 1, 0, 1, 1); lit(1, "scan b2", 1, 7, 1, 1);
      tick(); lit(0, "scan idle", 0, 0, 0, 0);

      // Backpressure holds the first beat
      iv = 1'b1;
      tick(); lit(0, "bp first", 1, 7, 1, 0);
      iv = 1'b0; ordy = 1'b0;
      tick(); tick(); tick(); lit(0, "bp held", 1, 7, 1, 0);
      ordy = 1'b1;
      tick(); lit(0, "bp resume", 1, 2, 1, 0);
      tick(); lit(0, "bp end", 1, 0, 1, 1);
      tick();

      // Zero vector, then en=0 blocks acceptance
      iv = 1'b1; xin = 16'h0000; md = 1'b1;
      tick(); lit(0, "zero", 1, 0, 0, 1); lit(2, "zero", 1, 0, 0, 1);
      iv = 1'b0;
      tick(); lit(0, "zero idle", 0, 0, 0, 0);
      en = 1'b0; iv = 1'b1; xin = 16'h00FF;
      tick(); chk("en0 in_ready", int'(a_ir[0]), 0);
      tick(); lit(0, "en0 no accept", 0, 0, 0, 0);
      en = 1'b1; iv = 1'b0;

      // Reset mid-drain on the 16-bit instance
      tick();
      iv = 1'b1; xin = 16'h8001; md = 1'b1;
      tick(); lit(2, "w16 first", 1, 15, 1, 0);
      iv = 1'b0;
      pulse_reset("midrst");
      tick(); chk("midrst in_ready", int'(a_ir[2]), 1);
      iv = 1'b1; xin = 16'h0300;
      tick(); lit(2, "w16 after", 1, 9, 1, 0);
      iv = 1'b0;
      tick(); lit(2, "w16 last", 1, 8, 1, 1);
      tick();

      // All ones in scan mode yields WIDTH beats
      iv = 1'b1; xin = 16'hFFFF; md = 1'b1; ordy = 1'b1;
      b0 = 0; b2 = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i == 0) iv = 1'b0;
         if (a_ov[0]) b0++;
         if (a_ov[2]) b2++;
      end
      chk("ones beats w8", b0, 8);
      chk("ones beats w16", b2, 16);

      // Randomised traffic with occasional asynchronous resets
      for (int n = 0; n < 3000; n++) begin
         tick();
         en   = ($urandom_range(0, 9) != 0);
         iv   = ($urandom_range(0, 2) != 0);
         md   = 1'($urandom_range(0, 1));
         ordy = ($urandom_range(0, 3) != 0);
         r    = $urandom_range(0, 9);
         xin  = (r == 0) ? 16'h0000 : (r == 1) ? 16'hFFFF : 16'($urandom);
         if ($urandom_range(0, 149) == 0) pulse_reset("rndrst");
      end
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end
endmodule
`default_nettype wire
